// File: rtl/muldiv_ctrl.sv
// Multiply/divide controller with architectural HI/LO for the EX stage.
// Sequences a single-cycle multiply (MULT/MULTU) or a restoring divide
// (DIV/DIVU, one quotient bit per cycle). It stalls IF..EX while busy and
// owns every HI/LO write, including MTHI/MTLO.
// Ports:
//   clk, resetn        core clock (rising edge), async active-low reset
//   op_valid, op       mul/div instruction in EX; 00 MULT 01 MULTU 10 DIV 11 DIVU
//   a, b               rs / rt operands
//   flush              abort whatever is in EX
//   hi_we, lo_we       MTHI / MTLO write enables, data on wdata
//   stall              freeze IF..EX (combinational from state and op_valid)
//   busy               operation in flight (MUL or DIV state)
//   done               one-cycle completion pulse
//   hi, lo             architectural HI / LO registers
module muldiv_ctrl #(
    parameter int unsigned DIV_STEPS = 32
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        op_valid,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned W  = 32;
    localparam int unsigned CW = $clog2(DIV_STEPS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          state, state_nxt;
    logic            accept;
    logic            res_we;

    logic [W-1:0]    a_q, b_q;
    logic            sgn_q;
    logic [CW-1:0]   cnt;
    logic [W-1:0]    quo, rem, dvs;
    logic [2*W-1:0]  prod;

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_nxt;
    end

    // Next-state, stall and result-write control
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        res_we    = 1'b0;
        stall     = 1'b0;
        case (state)
            S_IDLE: begin
                if (op_valid && !flush) begin
                    accept    = 1'b1;
                    stall     = 1'b1;
                    state_nxt = op[1] ? S_DIV : S_MUL;
                end
            end
            S_MUL: begin
                stall = 1'b1;
                if (flush) begin
                    state_nxt = S_IDLE;
                end else begin
                    res_we    = 1'b1;
                    state_nxt = S_DONE;
                end
            end
            S_DIV: begin
                stall = 1'b1;
                if (flush) begin
                    state_nxt = S_IDLE;
                end else if (cnt == CW'(DIV_STEPS - 1)) begin
                    res_we    = 1'b1;
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                // Same instruction still sits in EX; op_valid is ignored here.
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign busy = (state == S_MUL) || (state == S_DIV);
    assign done = (state == S_DONE);

    // Operand conditioning at accept
    logic           sgn_op;
    logic [W-1:0]   a_mag, b_mag;
    logic [2*W-1:0] mul_s, mul_u;

    always_comb begin
        sgn_op = !op[0];
        a_mag  = (sgn_op && a[W-1]) ? (W'(0) - a) : a;
        b_mag  = (sgn_op && b[W-1]) ? (W'(0) - b) : b;
        mul_s  = (2*W)'($signed(a)) * (2*W)'($signed(b));
        mul_u  = (2*W)'(a) * (2*W)'(b);
    end

    // One restoring step; the shifted partial remainder needs W+1 bits
    logic [W:0]     shifted;
    logic [W+1:0]   diff;
    logic           fits;
    logic [W-1:0]   quo_nxt, rem_nxt;

    always_comb begin
        shifted = {rem, quo[W-1]};
        diff    = {1'b0, shifted} - {2'b00, dvs};
        fits    = !diff[W+1];
        quo_nxt = {quo[W-2:0], fits};
        rem_nxt = fits ? diff[W-1:0] : shifted[W-1:0];
    end

    // Final result selection with signed fix-up and divide-by-zero bypass
    logic [W-1:0]   res_hi, res_lo;
    logic           neg_q, neg_r;

    always_comb begin
        neg_q  = sgn_q && (a_q[W-1] ^ b_q[W-1]);
        neg_r  = sgn_q && a_q[W-1];
        res_hi = prod[2*W-1:W];
        res_lo = prod[W-1:0];
        if (state == S_DIV) begin
            if (b_q == W'(0)) begin
                res_lo = '1;
                res_hi = a_q;
            end else begin
                res_lo = neg_q ? (W'(0) - quo_nxt) : quo_nxt;
                res_hi = neg_r ? (W'(0) - rem_nxt) : rem_nxt;
            end
        end
    end

    // Operand latch and divide datapath
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            a_q   <= '0;
            b_q   <= '0;
            sgn_q <= 1'b0;
            cnt   <= '0;
            quo   <= '0;
            rem   <= '0;
            dvs   <= '0;
            prod  <= '0;
        end else if (accept) begin
            a_q   <= a;
            b_q   <= b;
            sgn_q <= sgn_op;
            cnt   <= '0;
            quo   <= a_mag;
            rem   <= '0;
            dvs   <= b_mag;
            prod  <= sgn_op ? mul_s : mul_u;
        end else if (state == S_DIV && !flush) begin
            cnt   <= cnt + CW'(1);
            quo   <= quo_nxt;
            rem   <= rem_nxt;
        end
    end

    // HI/LO: an operation result beats MTHI/MTLO on the same edge
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hi <= '0;
            lo <= '0;
        end else begin
            if (res_we)     hi <= res_hi;
            else if (hi_we) hi <= wdata;
            if (res_we)     lo <= res_lo;
            else if (lo_we) lo <= wdata;
        end
    end

endmodule
